vram_write_scheduler: RTL
=========================

Name: vram_write_scheduler

Overview:
- Owns the single write port of the 32x32-cell, 3-bit-colour video memory.
- Shares that port between two requesters:
  - CPU single-cell writes (WVM instruction). These cannot stall and always have priority.
  - A hardware rectangle-fill engine. It sweeps a cell region row by row and yields any cycle the CPU writes.
- Sits between the CPU execute stage and the video memory write inputs (write enable, address, data).

Parameters:
- COORD_WIDTH, 5, bits per cell coordinate. Address width = 2*COORD_WIDTH.
- COLOR_WIDTH, 3, colour bits per cell.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iCpuWrite  in  1  CPU write request, single-cycle, non-stallable.
- iCpuAddress  in  10  CPU cell address {row[4:0],col[4:0]}.
- iCpuColor  in  3  CPU write colour.
- iFillStart  in  1  fill request pulse. Sampled only in IDLE.
- iFillX0  in  5  fill corner A column.
- iFillY0  in  5  fill corner A row.
- iFillX1  in  5  fill corner B column.
- iFillY1  in  5  fill corner B row.
- iFillColor  in  3  fill colour.
- iAbort  in  1  cancel the fill in progress.
- oWriteEnable  out  1  video memory write enable (registered).
- oWriteAddress  out  10  video memory write address (registered).
- oDataOut  out  3  video memory write data (registered).
- oBusy  out  1  high while state != IDLE.
- oDone  out  1  one-cycle pulse, high in the cycle the last fill write is on the outputs.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE.
  - oWriteEnable=0, oWriteAddress=0, oDataOut=0, oBusy=0, oDone=0.
  - Latched coordinates, colour and cursor cleared.
  - Reset mid-fill drops the fill entirely; no further writes after release.
- All outputs are registered. A CPU write sampled at edge E appears on the outputs after E (1-cycle latency).
- Output mux at each edge:
  - iCpuWrite=1: oWriteEnable=1, oWriteAddress=iCpuAddress, oDataOut=iCpuColor. CPU always wins.
  - Otherwise, state==FILL: write the cursor cell with the latched colour, then advance the cursor.
  - Otherwise: oWriteEnable=0. Address and data hold their last value.
- State IDLE:
  - iFillStart=1 latches xmin=min(X0,X1), xmax=max(X0,X1), ymin=min(Y0,Y1), ymax=max(Y0,Y1), and the colour.
  - Cursor is set to (xmin,ymin); go to FILL.
  - A concurrent CPU write is still issued that same edge.
- State FILL:
  - Each fill-write edge outputs address {cursorY,cursorX}.
  - Cursor advance: if cursorX==xmax, then cursorX=xmin and cursorY++; else cursorX++.
  - When the cell written is (xmax,ymax), go to DONE.
  - On CPU-write edges the cursor holds; the fill resumes the next edge.
  - The first fill write appears on the outputs after the edge following the start sample, assuming no CPU write.
  - Total fill writes = (xmax-xmin+1)*(ymax-ymin+1), in row-major ascending order, no duplicates or skips.
  - Degenerate 1x1 region: exactly one write, then DONE.
- State DONE:
  - oDone=1 for exactly one cycle, coincident with the last fill write on the outputs.
  - Next edge returns to IDLE. A CPU write is still honoured here.
- iAbort=1 in FILL or DONE:
  - Next state is IDLE; no fill write is issued that edge.
  - oDone is not pulsed.
  - A simultaneous CPU write is still issued.
  - iAbort in IDLE has no effect.
- Ignored inputs and wrap rules:
  - iFillStart while oBusy=1 is ignored; coordinates and colour are not re-latched.
  - No address wrap beyond 1023. The coordinate range is bounded by COORD_WIDTH.
  - cursorY never increments past ymax.
- oBusy=1 in FILL and DONE.

Test Plan:
- Reset released, fill X0=0,Y0=0,X1=31,Y1=31, colour 3'b101, no CPU writes -> 1024 consecutive writes, addresses 0..1023, data 5. oDone pulses once with address 1023. oBusy falls one cycle later.
- Fill X0=7,Y0=2,X1=4,Y1=1 (swapped corners), colour 2 -> addresses in order 36,37,38,39,68,69,70,71 (8 writes), then oDone.
- Fill (3,3)-(3,3) -> exactly one write, address 99 (3*32+3), oDone in that same cycle.
- Fill (0,0)-(3,0); CPU write addr 500, colour 6 on the second fill cycle -> output sequence 0, 500(data 6), 1, 2, 3. Fill takes 5 cycles; oDone with address 3.
- Fill (0,0)-(31,31) with iAbort after 10 fill writes -> no further fill writes, oDone never pulses, oBusy=0 next cycle. A new iFillStart is accepted afterwards.
- Reset (driven low) asserted mid-fill, then released -> outputs 0 immediately, no writes after release. iFillStart asserted while busy, in a separate run, does not alter the region or colour.

Source files
------------

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//   Owns the single write port of the 32x32-cell video memory and shares it
//   between CPU single-cell writes (never stalled, always win) and a
//   rectangle-fill engine that sweeps its region row-major and yields any
//   cycle the CPU writes.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no fill active; iFillStart latches a region and colour
//   FILL  | one fill write per non-CPU cycle, cursor walks the region
//   DONE  | last fill write is on the outputs (oDone high); back to IDLE
//
// Ports
//   Clock, Reset                 rising-edge clock, async active-low reset
//   iCpuWrite/Address/Color      CPU cell write, issued the following cycle
//   iFillStart, iFillX0..Y1      fill request and opposite region corners
//   iFillColor                   fill colour
//   iAbort                       cancel the fill in progress
//   oWriteEnable/Address/DataOut registered video memory write port
//   oBusy                        high while a fill is in FILL or DONE
//   oDone                        one-cycle pulse with the last fill write

module vram_write_scheduler #(
    parameter int COORD_WIDTH = 5,
    parameter int COLOR_WIDTH = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     iCpuWrite,
    input  logic [2*COORD_WIDTH-1:0] iCpuAddress,
    input  logic [COLOR_WIDTH-1:0]   iCpuColor,
    input  logic                     iFillStart,
    input  logic [COORD_WIDTH-1:0]   iFillX0,
    input  logic [COORD_WIDTH-1:0]   iFillY0,
    input  logic [COORD_WIDTH-1:0]   iFillX1,
    input  logic [COORD_WIDTH-1:0]   iFillY1,
    input  logic [COLOR_WIDTH-1:0]   iFillColor,
    input  logic                     iAbort,
    output logic                     oWriteEnable,
    output logic [2*COORD_WIDTH-1:0] oWriteAddress,
    output logic [COLOR_WIDTH-1:0]   oDataOut,
    output logic                     oBusy,
    output logic                     oDone
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [COORD_WIDTH-1:0] xMin;
    logic [COORD_WIDTH-1:0] xMax;
    logic [COORD_WIDTH-1:0] yMin;
    logic [COORD_WIDTH-1:0] yMax;
    logic [COORD_WIDTH-1:0] cursorX;
    logic [COORD_WIDTH-1:0] cursorY;
    logic [COLOR_WIDTH-1:0] fillColor;

    logic                   lastCell;
    logic                   fillSlot;
    logic [COORD_WIDTH-1:0] startXMin;
    logic [COORD_WIDTH-1:0] startXMax;
    logic [COORD_WIDTH-1:0] startYMin;
    logic [COORD_WIDTH-1:0] startYMax;

    // Corners may arrive in any order; normalise them before latching.
    assign startXMin = (iFillX0 < iFillX1) ? iFillX0 : iFillX1;
    assign startXMax = (iFillX0 < iFillX1) ? iFillX1 : iFillX0;
    assign startYMin = (iFillY0 < iFillY1) ? iFillY0 : iFillY1;
    assign startYMax = (iFillY0 < iFillY1) ? iFillY1 : iFillY0;

    assign lastCell = (cursorX == xMax) && (cursorY == yMax);

    // The fill engine owns the port only when the CPU is silent and the
    // fill is not being cancelled this edge.
    assign fillSlot = (state == FILL) && !iCpuWrite && !iAbort;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            xMin          <= '0;
            xMax          <= '0;
            yMin          <= '0;
            yMax          <= '0;
            cursorX       <= '0;
            cursorY       <= '0;
            fillColor     <= '0;
            oWriteEnable  <= 1'b0;
            oWriteAddress <= '0;
            oDataOut      <= '0;
            oBusy         <= 1'b0;
            oDone         <= 1'b0;
        end else begin
            oDone <= 1'b0;

            // Write port mux: CPU first, then the fill cursor; address and
            // data hold their last value on idle cycles.
            if (iCpuWrite) begin
                oWriteEnable  <= 1'b1;
                oWriteAddress <= iCpuAddress;
                oDataOut      <= iCpuColor;
            end else if (fillSlot) begin
                oWriteEnable  <= 1'b1;
                oWriteAddress <= {cursorY, cursorX};
                oDataOut      <= fillColor;
            end else begin
                oWriteEnable  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (iFillStart) begin
                        xMin      <= startXMin;
                        xMax      <= startXMax;
                        yMin      <= startYMin;
                        yMax      <= startYMax;
                        cursorX   <= startXMin;
                        cursorY   <= startYMin;
                        fillColor <= iFillColor;
                        state     <= FILL;
                        oBusy     <= 1'b1;
                    end
                end

                FILL: begin
                    if (iAbort) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end else if (fillSlot) begin
                        if (lastCell) begin
                            // Cursor is left on the final cell; it is
                            // reloaded by the next start.
                            state <= DONE;
                            oDone <= 1'b1;
                        end else if (cursorX == xMax) begin
                            cursorX <= xMin;
                            cursorY <= cursorY + 1'b1;
                        end else begin
                            cursorX <= cursorX + 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule
